// File: rtl/mult_register_unit.sv
// mult_register_unit
// Datapath registers for the add-shift signed multiplier.
// Holds the sign-extension bit X, accumulator A and multiplier B.
// A 9-bit signed adder/subtractor combines A with the switch operand S.
// The external controller issues the clearA/loadA/loadB/shift/add_sub strobes.
// M (B[0]) is returned to that controller.
// This block has no sequencing of its own. Every strobe takes effect on the
// next rising edge of clk.
module mult_register_unit #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clearA,
  input  logic               loadA,
  input  logic               loadB,
  input  logic               shift,
  input  logic               add_sub,
  input  logic [WIDTH-1:0]   S,
  output logic               X,
  output logic [WIDTH-1:0]   Aval,
  output logic [WIDTH-1:0]   Bval,
  output logic               M,
  output logic [2*WIDTH-1:0] product
);

  logic             x_q, x_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;

  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   s_ext;
  logic [WIDTH:0]   s_opnd;
  logic [WIDTH:0]   sum;

  // Signed adder/subtractor. Both operands are sign-extended by one bit, so
  // the 9-bit result holds every 8-bit sum or difference. For example,
  // 0 - (-128) gives +128. Subtraction inverts S and injects add_sub as the
  // carry-in. The carry out of the top bit is dropped.
  always_comb begin
    a_ext  = {a_q[WIDTH-1], a_q};
    s_ext  = {S[WIDTH-1], S};
    s_opnd = s_ext ^ {(WIDTH+1){add_sub}};
    sum    = a_ext + s_opnd + {{WIDTH{1'b0}}, add_sub};
  end

  // Next-state logic for the two independent register groups.
  // For {X,A} the priority is clearA > loadA > shift > hold.
  // For B the priority is loadB > shift > hold.
  // B shifts in the pre-edge A[0] even when loadA claims A in the same cycle.
  // S only reaches a register when loadA or loadB is set, so an undriven S
  // cannot disturb held state.
  always_comb begin
    x_d = x_q;
    a_d = a_q;
    b_d = b_q;

    if (clearA) begin
      x_d = 1'b0;
      a_d = '0;
    end else if (loadA) begin
      x_d = sum[WIDTH];
      a_d = sum[WIDTH-1:0];
    end else if (shift) begin
      a_d = {x_q, a_q[WIDTH-1:1]};
    end

    if (loadB) begin
      b_d = S;
    end else if (shift) begin
      b_d = {a_q[0], b_q[WIDTH-1:1]};
    end
  end

  // State registers. Reset clears everything immediately, with no clock edge needed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      x_q <= x_d;
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  // Outputs come straight from the registers. M feeds back to the controller.
  always_comb begin
    X       = x_q;
    Aval    = a_q;
    Bval    = b_q;
    M       = b_q[0];
    product = {a_q, b_q};
  end

endmodule

// File: tb/tb_mult_register_unit.sv
// tb_mult_register_unit
// Directed-vector bench for mult_register_unit.
// Expected values are hand-computed constants.
module tb_mult_register_unit;

  localparam int W = 8;

  logic           clk;
  logic           reset;
  logic           clearA;
  logic           loadA;
  logic           loadB;
  logic           shift;
  logic           add_sub;
  logic [W-1:0]   S;
  logic           X;
  logic [W-1:0]   Aval;
  logic [W-1:0]   Bval;
  logic           M;
  logic [2*W-1:0] product;

  int n_checks;
  int n_fail;

  mult_register_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .clearA  (clearA),
    .loadA   (loadA),
    .loadB   (loadB),
    .shift   (shift),
    .add_sub (add_sub),
    .S       (S),
    .X       (X),
    .Aval    (Aval),
    .Bval    (Bval),
    .M       (M),
    .product (product)
  );

  // Clock: 10 time-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single checking task; every comparison goes through here.
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply the currently driven strobes for one rising edge, then drop them.
  // On return we are 1 time unit after the edge, which is where outputs are sampled.
  task automatic tick();
    @(posedge clk);
    #1;
    clearA  = 1'b0;
    loadA   = 1'b0;
    loadB   = 1'b0;
    shift   = 1'b0;
    add_sub = 1'b0;
  endtask

  // Controller model: load the multiplier into B, then run 8 steps.
  // Each step adds when M=1 (subtracting on step 8) and then shifts.
  task automatic run_multiply(input logic [W-1:0] mcand, input logic [W-1:0] mplier);
    S = mplier;
    clearA = 1'b1;
    loadB = 1'b1;
    tick();
    S = mcand;
    for (int i = 1; i <= 8; i++) begin
      if (M) begin
        loadA = 1'b1;
        add_sub = (i == 8);
        tick();
      end
      shift = 1'b1;
      tick();
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    clearA   = 1'b0;
    loadA    = 1'b0;
    loadB    = 1'b0;
    shift    = 1'b0;
    add_sub  = 1'b0;
    S        = '0;

    #12;
    check("reset_x", {15'd0, X}, 16'h0000);
    check("reset_product", product, 16'h0000);
    check("reset_m", {15'd0, M}, 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    // Preload A=0x55, B=0xAA, X=1: 0xAB + 0xAA = -171 = 9'h155
    S = 8'hAB; clearA = 1'b1; tick();
    S = 8'hAB; loadA = 1'b1; tick();
    S = 8'hAA; loadA = 1'b1; loadB = 1'b1; tick();
    check("preload_x", {15'd0, X}, 16'h0001);
    check("preload_a", {8'd0, Aval}, 16'h0055);
    check("preload_b", {8'd0, Bval}, 16'h00AA);

    // Async reset between edges clears the state before the next edge.
    #2;
    reset = 1'b1;
    #1;
    check("async_x", {15'd0, X}, 16'h0000);
    check("async_a", {8'd0, Aval}, 16'h0000);
    check("async_b", {8'd0, Bval}, 16'h0000);
    check("async_m", {15'd0, M}, 16'h0000);

    // While reset is held, strobes must have no effect.
    S = 8'h11; loadA = 1'b1; loadB = 1'b1;
    @(posedge clk); #1;
    check("held_reset_a", {8'd0, Aval}, 16'h0000);
    reset = 1'b0;
    tick();
    check("post_reset_a", {8'd0, Aval}, 16'h0011);
    check("post_reset_b", {8'd0, Bval}, 16'h0011);

    // Clear A / load B in the same cycle.
    S = 8'h07; clearA = 1'b1; loadB = 1'b1; tick();
    check("clr_load_a", {8'd0, Aval}, 16'h0000);
    check("clr_load_x", {15'd0, X}, 16'h0000);
    check("clr_load_b", {8'd0, Bval}, 16'h0007);
    check("clr_load_m", {15'd0, M}, 16'h0001);

    // Add, then shift.
    S = 8'hFD; loadA = 1'b1; add_sub = 1'b0; tick();
    check("add_x", {15'd0, X}, 16'h0001);
    check("add_a", {8'd0, Aval}, 16'h00FD);
    shift = 1'b1; tick();
    check("shift_x", {15'd0, X}, 16'h0001);
    check("shift_a", {8'd0, Aval}, 16'h00FE);
    check("shift_b", {8'd0, Bval}, 16'h0083);

    // Subtract edge case: 0 - (-128) = +128
    clearA = 1'b1; tick();
    S = 8'h80; loadA = 1'b1; add_sub = 1'b1; tick();
    check("sub_edge_x", {15'd0, X}, 16'h0000);
    check("sub_edge_a", {8'd0, Aval}, 16'h0080);

    // Full multiplies
    run_multiply(8'hFD, 8'h07);
    check("mul_7x-3_prod", product, 16'hFFEB);
    check("mul_7x-3_x", {15'd0, X}, 16'h0001);
    run_multiply(8'h80, 8'h80);
    check("mul_-128sq_prod", product, 16'h4000);
    check("mul_-128sq_x", {15'd0, X}, 16'h0000);
    run_multiply(8'h5A, 8'h00);
    check("mul_zero_prod", product, 16'h0000);

    // loadA + shift conflict: A takes the load, B shifts in the pre-edge A[0].
    S = 8'h00; clearA = 1'b1; loadB = 1'b1; tick();
    S = 8'h01; loadA = 1'b1; tick();
    S = 8'h01; loadA = 1'b1; shift = 1'b1; add_sub = 1'b0; tick();
    check("conf_la_sh_a", {8'd0, Aval}, 16'h0002);
    check("conf_la_sh_x", {15'd0, X}, 16'h0000);
    check("conf_la_sh_b", {8'd0, Bval}, 16'h0080);

    // clearA wins over loadA
    S = 8'h33; clearA = 1'b1; loadA = 1'b1; tick();
    check("conf_clr_la_a", {8'd0, Aval}, 16'h0000);
    check("conf_clr_la_x", {15'd0, X}, 16'h0000);

    // loadB + shift: B loads S while {X,A} shifts.
    S = 8'h84; loadA = 1'b1; tick();
    S = 8'h3C; loadB = 1'b1; shift = 1'b1; tick();
    check("conf_lb_sh_b", {8'd0, Bval}, 16'h003C);
    check("conf_lb_sh_a", {8'd0, Aval}, 16'h00C2);
    check("conf_lb_sh_x", {15'd0, X}, 16'h0001);

    // Hold with no strobes
    S = 8'hFF; tick();
    check("hold_product", product, 16'hC23C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
